// File: rtl/io_bridge_pkg.sv
// Shared defaults and types for the core-to-device I/O bridge.
package io_bridge_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;

  // Inbound holding register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } in_state_t;

endpackage

// File: rtl/io_out_fifo.sv
// Show-ahead outbound FIFO: core writes are queued and drained to the device
// over a valid/ready handshake; writes that find it full are dropped and flagged.
module io_out_fifo
  import io_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       overflow,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              push;
  logic              pop;

  assign rd_valid = (count != '0);
  assign full     = (count == CNT_FULL);
  assign rd_data  = mem[rptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Bridges the core's Output/IOIn pins to an external device: outbound words go
// through a FIFO, inbound words land in a single holding register.
// Handshake rule for both device links: a word transfers on a rising edge where
// valid and ready are both 1; valid-side data must be stable while waiting.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] OutData,
  input  logic              OutWrite,
  output logic              OutFull,
  output logic              Overflow,
  output logic [DATA_W-1:0] DevData,
  output logic              DevValid,
  input  logic              DevReady,
  input  logic [DATA_W-1:0] DevInData,
  input  logic              DevInValid,
  output logic              DevInReady,
  output logic [DATA_W-1:0] IOIn,
  output logic              InAvail,
  input  logic              InRead,
  output in_state_t         in_state_dbg,
  output logic [$clog2(DEPTH):0] out_count_dbg
);

  in_state_t in_state;

  io_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_out_fifo (
    .clk      (CLK),
    .rst_n    (reset),
    .wr_data  (OutData),
    .wr_en    (OutWrite),
    .full     (OutFull),
    .overflow (Overflow),
    .rd_data  (DevData),
    .rd_valid (DevValid),
    .rd_ready (DevReady),
    .count    (out_count_dbg)
  );

  // A read in the same cycle frees the register, letting the device stream.
  assign DevInReady   = (in_state == EMPTY) || InRead;
  assign InAvail      = (in_state == FULL);
  assign in_state_dbg = in_state;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      in_state <= EMPTY;
      IOIn     <= '0;
    end else begin
      case (in_state)
        EMPTY: begin
          if (DevInValid) begin
            IOIn     <= DevInData;
            in_state <= FULL;
          end
        end
        FULL: begin
          if (InRead) begin
            if (DevInValid) IOIn <= DevInData;
            else            in_state <= EMPTY;
          end
        end
        default: in_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge against a queue-based reference model.
module tb_io_port_bridge;
  import io_bridge_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic [W-1:0]  OutData;
  logic          OutWrite;
  logic          OutFull;
  logic          Overflow;
  logic [W-1:0]  DevData;
  logic          DevValid;
  logic          DevReady;
  logic [W-1:0]  DevInData;
  logic          DevInValid;
  logic          DevInReady;
  logic [W-1:0]  IOIn;
  logic          InAvail;
  logic          InRead;
  in_state_t     in_state_dbg;
  logic [$clog2(D):0] out_count_dbg;

  io_port_bridge #(.DATA_W(W), .DEPTH(D)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .OutData      (OutData),
    .OutWrite     (OutWrite),
    .OutFull      (OutFull),
    .Overflow     (Overflow),
    .DevData      (DevData),
    .DevValid     (DevValid),
    .DevReady     (DevReady),
    .DevInData    (DevInData),
    .DevInValid   (DevInValid),
    .DevInReady   (DevInReady),
    .IOIn         (IOIn),
    .InAvail      (InAvail),
    .InRead       (InRead),
    .in_state_dbg (in_state_dbg),
    .out_count_dbg(out_count_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model state
  logic [W-1:0] exp_q[$];
  bit           m_ovf;
  logic [W-1:0] m_io;
  bit           m_avail;
  logic [W-1:0] last_drained;

  int checks = 0;
  int passed = 0;

  // Advance one edge; the model consumes the inputs that the edge samples.
  task automatic cycle();
    bit pop;
    bit full;
    bit rdy;
    @(posedge CLK);
    if (!reset) begin
      exp_q.delete();
      m_ovf   = 0;
      m_io    = '0;
      m_avail = 0;
    end else begin
      full = (exp_q.size() == D);
      pop  = (exp_q.size() != 0) && DevReady;
      if (pop) last_drained = exp_q.pop_front();
      if (OutWrite) begin
        if (!full || pop) exp_q.push_back(OutData);
        else m_ovf = 1;
      end
      rdy = !m_avail || InRead;
      if (DevInValid && rdy) begin
        m_io    = DevInData;
        m_avail = 1;
      end else if (m_avail && InRead) begin
        m_avail = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    OutData = '0; OutWrite = 0; DevReady = 0;
    DevInData = '0; DevInValid = 0; InRead = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 0;
    cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      OutData = W'($urandom); OutWrite = 1'($urandom); DevReady = 1'($urandom);
      DevInData = W'($urandom); DevInValid = 1'($urandom); InRead = 1'($urandom);
      cycle();
    end
    #1;
    checks++; if (OutFull !== 1'b0) $display("FAIL reset_outfull got=%b exp=0", OutFull); else passed++;
    checks++; if (Overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", Overflow); else passed++;
    checks++; if (DevData !== 16'h0) $display("FAIL reset_devdata got=%h exp=0000", DevData); else passed++;
    checks++; if (DevValid !== 1'b0) $display("FAIL reset_devvalid got=%b exp=0", DevValid); else passed++;
    checks++; if (IOIn !== 16'h0) $display("FAIL reset_ioin got=%h exp=0000", IOIn); else passed++;
    checks++; if (InAvail !== 1'b0) $display("FAIL reset_inavail got=%b exp=0", InAvail); else passed++;
    checks++; if (DevInReady !== 1'b1) $display("FAIL reset_devinready got=%b exp=1", DevInReady); else passed++;
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    reset_dut();
    foreach (words[i]) begin
      OutData = words[i]; OutWrite = 1; cycle();
    end
    OutWrite = 0; #1;
    checks++; if (OutFull !== 1'b1) $display("FAIL fill_outfull got=%b exp=1", OutFull); else passed++;
    OutData = 16'h5555; OutWrite = 1; cycle(); OutWrite = 0; #1;
    checks++; if (Overflow !== 1'b1 || !m_ovf) $display("FAIL overflow_set got=%b exp=1", Overflow); else passed++;
    checks++; if (exp_q.size() != 4) $display("FAIL overflow_model_depth got=%0d exp=4", exp_q.size()); else passed++;
    DevReady = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (DevValid !== 1'b1 || DevData !== words[i] || exp_q[0] !== words[i])
        $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, DevData, DevValid, words[i]);
      else passed++;
      cycle();
    end
    DevReady = 0; #1;
    checks++; if (DevValid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", DevValid); else passed++;
  endtask

  task automatic test_full_push_pop();
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      OutData = W'(16'h0101 * i); OutWrite = 1; cycle();
    end
    OutData = 16'hAAAA; OutWrite = 1; DevReady = 1; cycle();
    OutWrite = 0; DevReady = 0; #1;
    checks++; if (OutFull !== 1'b1 || out_count_dbg !== 3'd4) $display("FAIL pushpop_full got=%b cnt=%0d exp=1 cnt=4", OutFull, out_count_dbg); else passed++;
    checks++; if (Overflow !== 1'b0) $display("FAIL pushpop_overflow got=%b exp=0", Overflow); else passed++;
    checks++; if (DevData !== 16'h0202) $display("FAIL pushpop_head got=%h exp=0202", DevData); else passed++;
    DevReady = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (DevData !== exp_q[0]) $display("FAIL pushpop_drain_%0d got=%h exp=%h", i, DevData, exp_q[0]);
      else passed++;
      cycle();
    end
    DevReady = 0; #1;
    checks++; if (last_drained !== 16'hAAAA || DevValid !== 1'b0) $display("FAIL pushpop_last got=%h/%b exp=aaaa/0", last_drained, DevValid); else passed++;
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int i = 1; i <= 10; i++) begin
      OutData = W'(i); OutWrite = 1; DevReady = 0; cycle();
      OutWrite = 0; #1;
      checks++;
      if (DevValid !== 1'b1 || DevData !== W'(i)) $display("FAIL wrap_%0d got=%h/%b exp=%h/1", i, DevData, DevValid, W'(i));
      else passed++;
      DevReady = 1; cycle(); DevReady = 0; #1;
      checks++;
      if (DevValid !== 1'b0 || last_drained !== W'(i)) $display("FAIL wrap_drain_%0d got=%b exp=0", i, DevValid);
      else passed++;
    end
  endtask

  task automatic test_inbound();
    reset_dut();
    DevInData = 16'hBEEF; DevInValid = 1; cycle();
    DevInData = 16'hCAFE; #1;
    checks++; if (IOIn !== 16'hBEEF || InAvail !== 1'b1) $display("FAIL in_capture got=%h/%b exp=beef/1", IOIn, InAvail); else passed++;
    checks++; if (DevInReady !== 1'b0) $display("FAIL in_stall_ready got=%b exp=0", DevInReady); else passed++;
    cycle(); #1;
    checks++; if (IOIn !== 16'hBEEF) $display("FAIL in_stall_hold got=%h exp=beef", IOIn); else passed++;
    InRead = 1; #1;
    checks++; if (DevInReady !== 1'b1) $display("FAIL in_bypass_ready got=%b exp=1", DevInReady); else passed++;
    cycle();
    DevInValid = 0; #1;
    checks++; if (IOIn !== 16'hCAFE || InAvail !== 1'b1) $display("FAIL in_bypass got=%h/%b exp=cafe/1", IOIn, InAvail); else passed++;
    cycle(); InRead = 0; #1;
    checks++; if (InAvail !== 1'b0 || IOIn !== 16'hCAFE) $display("FAIL in_read_empty got=%h/%b exp=cafe/0", IOIn, InAvail); else passed++;
    InRead = 1; cycle(); InRead = 0; #1;
    checks++; if (InAvail !== 1'b0) $display("FAIL in_read_ignored got=%b exp=0", InAvail); else passed++;
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      OutData = W'($urandom); OutWrite = 1; cycle();
    end
    OutWrite = 0;
    DevInData = 16'h1234; DevInValid = 1; cycle(); DevInValid = 0;
    reset = 0; OutWrite = 1; OutData = 16'h7777; DevInValid = 1; DevInData = 16'h9999; DevReady = 1;
    cycle();
    idle_inputs(); reset = 1; #1;
    checks++; if (DevValid !== 1'b0) $display("FAIL midrst_devvalid got=%b exp=0", DevValid); else passed++;
    checks++; if (InAvail !== 1'b0) $display("FAIL midrst_inavail got=%b exp=0", InAvail); else passed++;
    checks++; if (IOIn !== 16'h0) $display("FAIL midrst_ioin got=%h exp=0000", IOIn); else passed++;
    checks++; if (Overflow !== 1'b0) $display("FAIL midrst_overflow got=%b exp=0", Overflow); else passed++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      OutData    = W'($urandom);
      OutWrite   = ($urandom_range(0, 2) != 0);
      DevReady   = ($urandom_range(0, 2) == 0);
      DevInData  = W'($urandom);
      DevInValid = 1'($urandom);
      InRead     = 1'($urandom);
      #1;
      checks++;
      if (DevInReady !== (!m_avail || InRead)) $display("FAIL rnd_devinready n=%0d got=%b exp=%b", n, DevInReady, (!m_avail || InRead));
      else passed++;
      cycle(); #1;
      checks++;
      if (DevValid !== (exp_q.size() != 0) || OutFull !== (exp_q.size() == D) || Overflow !== m_ovf)
        $display("FAIL rnd_fifo_flags n=%0d got=v%b f%b o%b exp=v%b f%b o%b", n, DevValid, OutFull, Overflow,
                 (exp_q.size() != 0), (exp_q.size() == D), m_ovf);
      else passed++;
      if (exp_q.size() != 0) begin
        checks++;
        if (DevData !== exp_q[0]) $display("FAIL rnd_devdata n=%0d got=%h exp=%h", n, DevData, exp_q[0]);
        else passed++;
      end
      checks++;
      if (InAvail !== m_avail || IOIn !== m_io) $display("FAIL rnd_inbound n=%0d got=%h/%b exp=%h/%b", n, IOIn, InAvail, m_io, m_avail);
      else passed++;
    end
    idle_inputs(); reset = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    last_drained = '0;
    m_io = '0;
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_inbound();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Buffers the processor's 16-bit I/O traffic between the accumulator core and an external device. Outbound words are queued in a small FIFO and drained to the device over a valid/ready handshake. Inbound device words are captured into a single holding register that drives the core's `IOIn` bus. The bridge sits directly on the core's `Output`/`IOIn` pins. The memory subsystem supplies the write and read strobes on IO-mapped accesses.

## Interface
Parameters:
- `DATA_W`, 16, I/O word width
- `DEPTH`, 4, outbound FIFO entries; power of two, ≥2

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `CLK` rising edge
- `OutData`  in  DATA_W  word from core (`Output` bus)
- `OutWrite`  in  1  one-cycle strobe: enqueue `OutData`
- `OutFull`  out  1  FIFO holds DEPTH entries
- `Overflow`  out  1  sticky: an `OutWrite` was dropped
- `DevData`  out  DATA_W  FIFO head word to device
- `DevValid`  out  1  FIFO non-empty
- `DevReady`  in  1  device accepts `DevData` this cycle
- `DevInData`  in  DATA_W  word from device
- `DevInValid`  in  1  device offers `DevInData`
- `DevInReady`  out  1  bridge accepts `DevInData` this cycle
- `IOIn`  out  DATA_W  held input word to core
- `InAvail`  out  1  holding register contains an unread word
- `InRead`  in  1  one-cycle strobe: core consumed `IOIn`

## Operation
- Reset (`reset`=0 at an edge) clears the FIFO pointers, count, `Overflow`, holding register and `InAvail` at that edge. Reset overrides all strobes in the same cycle.
- After reset, every output is 0 and `DevInReady`=1.
- Outbound FIFO is show-ahead.
  - `DevData` = entry at read pointer; `DevValid` = (count≠0); `OutFull` = (count==DEPTH).
  - Pop occurs when `DevValid && DevReady`.
  - Push occurs when `OutWrite && (count<DEPTH || pop)`. When full, a simultaneous push and pop is legal, and count stays at DEPTH.
  - An `OutWrite` while full with no pop is dropped: FIFO is unchanged and `Overflow` is set to 1. `Overflow` clears only on reset.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - `DevReady` while empty has no effect.
  - `DevData` is undefined-but-stable while `DevValid`=0; it shows the stale entry and has no X's after reset. Storage is cleared at reset.
- Inbound holding register is a 2-state FSM: EMPTY (`InAvail`=0) and FULL (`InAvail`=1).
  - `DevInReady` = EMPTY || `InRead` (combinational bypass).
  - In EMPTY, `DevInValid` → capture `DevInData` into `IOIn`, go to FULL.
  - In FULL, `InRead` && !`DevInValid` → EMPTY.
  - In FULL, `InRead` && `DevInValid` → capture the new word and stay FULL.
  - In FULL, with no `InRead`, the device is stalled (`DevInReady`=0).
  - `InRead` in EMPTY is ignored.
  - `IOIn` keeps the last captured word after a read. It changes only on capture or reset.

## Timing
- Enqueue latency: an `OutWrite` sampled at edge k makes `DevValid`=1 and `DevData`=word from edge k, which is visible in the cycle after edge k.
- FIFO throughput is one push and one pop per cycle. `OutFull`, `DevValid` and count update at the same edge as the push/pop.
- Inbound latency: a capture at edge k makes the new word appear on `IOIn` with `InAvail`=1 after edge k.
- Inbound throughput is one word per cycle when the core reads every cycle.
- `DevInReady` is the only combinational path from an input (`InRead`). There are no other input-to-output combinational paths.
- Reset mid-transfer discards all queued and held words. A handshake completing in the reset cycle is not performed.

## Structure
- Package `io_bridge_pkg`: `DATA_W`/`DEPTH` defaults and the `in_state_t` enum (EMPTY, FULL).
- Sub-module `io_out_fifo` holds the outbound FIFO: storage, pointers, count, full/overflow logic.
- The inbound FSM stays in the top module.

## Test plan
- Reset check: hold `reset`=0 for 2 cycles with random inputs → all outputs 0, `DevInReady`=1.
- Fill and overflow:
  - Write 0x1111, 0x2222, 0x3333, 0x4444 with `DevReady`=0 → `OutFull`=1.
  - Then write 0x5555 → `Overflow`=1 and FIFO contents unchanged.
  - Drain with `DevReady`=1 → 0x1111..0x4444 in order, then `DevValid`=0.
- Full push+pop: with the FIFO full, assert `OutWrite`=0xAAAA and `DevReady`=1 in the same cycle → head pops, count stays 4, `Overflow` stays 0, and 0xAAAA drains last.
- Wrap-around: run 10 single write-then-drain pairs (0x0001..0x000A) → each word appears on `DevData` one cycle after its write, in order, with no loss.
- Inbound stall and bypass:
  - Device offers 0xBEEF → `IOIn`=0xBEEF, `InAvail`=1.
  - Device then offers 0xCAFE with no `InRead` → `DevInReady`=0 and `IOIn` holds 0xBEEF.
  - Pulse `InRead` → 0xCAFE is captured in the same cycle and `InAvail` stays 1.
- Mid-operation reset: with 3 FIFO entries and FULL inbound, pulse `reset`=0 for one cycle → `DevValid`=0, `InAvail`=0, `IOIn`=0, `Overflow`=0.
